// File: rtl/transmissor_serial_paridade_pkg.sv
// Types, line-level constants and the even-parity helper shared by the serial
// transmitter and the even-parity detector bench.
package transmissor_serial_paridade_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } estado_t;

    localparam logic LINHA_OCIOSA = 1'b1;
    localparam logic BIT_START    = 1'b0;

    localparam int PAR_MAX_W = 64;

    // Callers zero-extend their word; padding zeros do not change the result.
    function automatic logic paridade_par(input logic [PAR_MAX_W-1:0] palavra);
        return ^palavra;
    endfunction

endpackage

// File: rtl/transmissor_serial_paridade.sv
// Even-parity serial transmitter: start, DATA_W bits LSB first, parity, STOP_BITS stops.
// Optional macro PARITY_FAULT_EN adds falha_paridade to invert the parity bit of a frame.
module transmissor_serial_paridade
    import transmissor_serial_paridade_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_en,
    input  logic [DATA_W-1:0] dado_in,
    input  logic              valid_in,
`ifdef PARITY_FAULT_EN
    input  logic              falha_paridade,
`endif
    output logic              ready_out,
    output logic              saida_serial,
    output logic              ocupado,
    output logic              quadro_fim
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_W - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_bits_invalido
        $error("STOP_BITS must be 1 or 2");
    end
    if (DATA_W < 1 || DATA_W > PAR_MAX_W) begin : g_data_w_invalido
        $error("DATA_W must be between 1 and 64");
    end

    estado_t           estado_q, estado_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stop_q, stop_d;
    logic              linha_q, linha_d;
    logic              fim_q, fim_d;
    logic              par_palavra;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= IDLE;
            shift_q  <= '0;
            par_q    <= 1'b0;
            cnt_q    <= '0;
            stop_q   <= 1'b0;
            linha_q  <= LINHA_OCIOSA;
            fim_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            cnt_q    <= cnt_d;
            stop_q   <= stop_d;
            linha_q  <= linha_d;
            fim_q    <= fim_d;
        end
    end

    always_comb begin
`ifdef PARITY_FAULT_EN
        par_palavra = paridade_par(PAR_MAX_W'(dado_in)) ^ falha_paridade;
`else
        par_palavra = paridade_par(PAR_MAX_W'(dado_in));
`endif
    end

    // bit_en is only looked at outside IDLE, so a strobe coinciding with
    // acceptance never shortens START.
    always_comb begin
        estado_d = estado_q;
        shift_d  = shift_q;
        par_d    = par_q;
        cnt_d    = cnt_q;
        stop_d   = stop_q;
        case (estado_q)
            IDLE: begin
                if (valid_in) begin
                    shift_d  = dado_in;
                    par_d    = par_palavra;
                    estado_d = START;
                end
            end
            START: begin
                if (bit_en) begin
                    cnt_d    = '0;
                    estado_d = DATA;
                end
            end
            DATA: begin
                if (bit_en) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        estado_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (bit_en) begin
                    stop_d   = 1'b0;
                    estado_d = STOP;
                end
            end
            STOP: begin
                if (bit_en) begin
                    if (stop_q == STOP_LAST) begin
                        estado_d = IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    // Line level is decoded from the next state so it changes on the same edge.
    always_comb begin
        linha_d = LINHA_OCIOSA;
        case (estado_d)
            IDLE:    linha_d = LINHA_OCIOSA;
            START:   linha_d = BIT_START;
            DATA:    linha_d = shift_d[0];
            PARITY:  linha_d = par_d;
            STOP:    linha_d = 1'b1;
            default: linha_d = LINHA_OCIOSA;
        endcase
        fim_d = (estado_q == STOP) && (estado_d == IDLE);
    end

    assign ready_out    = (estado_q == IDLE);
    assign ocupado      = (estado_q != IDLE);
    assign saida_serial = linha_q;
    assign quadro_fim   = fim_q;

endmodule

// File: tb/tb_transmissor_serial_paridade.sv
// Directed bench for transmissor_serial_paridade: a one-stop and a two-stop instance.
module tb_transmissor_serial_paridade;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_en, valid, ready, linha, ocupado, fim;
    logic [7:0] dado;
    logic       bit_en2, valid2, ready2, linha2, ocupado2, fim2;
    logic [7:0] dado2;
`ifdef PARITY_FAULT_EN
    logic       falha = 1'b0;
    logic       falha2 = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    transmissor_serial_paridade #(.DATA_W(8), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .bit_en(bit_en), .dado_in(dado), .valid_in(valid),
`ifdef PARITY_FAULT_EN
        .falha_paridade(falha),
`endif
        .ready_out(ready), .saida_serial(linha), .ocupado(ocupado), .quadro_fim(fim)
    );

    transmissor_serial_paridade #(.DATA_W(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .bit_en(bit_en2), .dado_in(dado2), .valid_in(valid2),
`ifdef PARITY_FAULT_EN
        .falha_paridade(falha2),
`endif
        .ready_out(ready2), .saida_serial(linha2), .ocupado(ocupado2), .quadro_fim(fim2)
    );

    typedef struct {
        logic [7:0]  dado;
        int          periodo;
        bit          ruido;
        logic [10:0] esperado;  // {stop, parity, d7..d0, start}
    } vetor_t;

    vetor_t tab[5];

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_cmp++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    // Called at a negedge with dut idle; leaves at the negedge after the quadro_fim cycle.
    task automatic enviar(input logic [7:0] d, input int p, input bit ruido, input logic [10:0] esp);
        check("ready_antes", 32'(ready), 1);
        dado   = d;
        valid  = 1'b1;
        bit_en = (p == 1);
        @(negedge clk);
        valid = 1'b0;
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < p; c++) begin
                check("linha", 32'(linha), 32'(esp[b]));
                check("fim_no_quadro", 32'(fim), 0);
                check("ocupado", 32'(ocupado), 1);
                check("ready_no_quadro", 32'(ready), 0);
                valid  = ruido && (c == 1);
                dado   = ruido ? 8'h00 : ~d;
                bit_en = (c == p - 1);
                @(negedge clk);
            end
        end
        valid  = 1'b0;
        bit_en = 1'b0;
        check("fim_pulso", 32'(fim), 1);
        check("linha_fim", 32'(linha), 1);
        check("ready_fim", 32'(ready), 1);
        check("ocupado_fim", 32'(ocupado), 0);
        @(negedge clk);
        check("fim_um_ciclo", 32'(fim), 0);
        check("linha_ociosa", 32'(linha), 1);
    endtask

    initial begin
        logic [11:0] esp2a, esp2b;

        tab[0] = '{8'hA5, 1, 1'b0, 11'b1_0_1010_0101_0};
        tab[1] = '{8'h07, 1, 1'b0, 11'b1_1_0000_0111_0};
        tab[2] = '{8'hFF, 4, 1'b1, 11'b1_0_1111_1111_0};
        tab[3] = '{8'h80, 2, 1'b0, 11'b1_1_1000_0000_0};
        tab[4] = '{8'h00, 3, 1'b1, 11'b1_0_0000_0000_0};

        reset = 1'b1;
        bit_en = 1'b0; valid = 1'b0; dado = 8'h00;
        bit_en2 = 1'b0; valid2 = 1'b0; dado2 = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_linha", 32'(linha), 1);
        check("rst_ready", 32'(ready), 1);
        check("rst_ocupado", 32'(ocupado), 0);
        check("rst_fim", 32'(fim), 0);
        check("rst_linha2", 32'(linha2), 1);
        check("rst_ready2", 32'(ready2), 1);
        reset = 1'b0;

        // bit_en while idle has no effect
        bit_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_bit_en_linha", 32'(linha), 1);
            check("idle_bit_en_ocupado", 32'(ocupado), 0);
        end
        bit_en = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            enviar(tab[i].dado, tab[i].periodo, tab[i].ruido, tab[i].esperado);
            @(negedge clk);
        end

        // Reset during DATA bit 3 of 0xA5
        dado = 8'hA5; valid = 1'b1; bit_en = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        check("antes_reset_bit3", 32'(linha), 0);
        check("antes_reset_ocupado", 32'(ocupado), 1);
        reset = 1'b1;
        #1;
        check("reset_linha", 32'(linha), 1);
        check("reset_ready", 32'(ready), 1);
        check("reset_ocupado", 32'(ocupado), 0);
        check("reset_fim", 32'(fim), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("pos_reset_fim", 32'(fim), 0);
            check("pos_reset_linha", 32'(linha), 1);
        end
        bit_en = 1'b0;
        enviar(8'h01, 1, 1'b0, 11'b1_1_0000_0001_0);

`ifdef PARITY_FAULT_EN
        @(negedge clk);
        falha = 1'b1;
        enviar(8'hA5, 1, 1'b0, 11'b1_1_1010_0101_0);
        falha = 1'b0;
`endif

        // Two stop bits, back-to-back frame accepted in the quadro_fim cycle
        esp2a = 12'b1_1_0_0011_1100_0;
        esp2b = 12'b1_1_0_1000_0001_0;
        @(negedge clk);
        dado2 = 8'h3C; valid2 = 1'b1; bit_en2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        for (int b = 0; b < 12; b++) begin
            check("linha2_a", 32'(linha2), 32'(esp2a[b]));
            check("fim2_a_no_quadro", 32'(fim2), 0);
            @(negedge clk);
        end
        check("fim2_a", 32'(fim2), 1);
        check("ready2_a_fim", 32'(ready2), 1);
        check("linha2_a_fim", 32'(linha2), 1);
        dado2 = 8'h81; valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        dado2 = 8'hFF;
        for (int b = 0; b < 12; b++) begin
            check("linha2_b", 32'(linha2), 32'(esp2b[b]));
            check("fim2_b_no_quadro", 32'(fim2), 0);
            check("ocupado2_b", 32'(ocupado2), 1);
            @(negedge clk);
        end
        check("fim2_b", 32'(fim2), 1);
        bit_en2 = 1'b0;
        @(negedge clk);
        check("fim2_b_um_ciclo", 32'(fim2), 0);
        check("linha2_ociosa", 32'(linha2), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/transmissor_serial_paridade.md
# transmissor_serial_paridade

- Parallel-to-serial transmitter for the even-parity serial path.
- Accepts one DATA_W-bit word per valid/ready handshake and emits the frame on a single line, LSB first: start bit, data bits, even-parity bit, stop bit(s).
- Advances one bit per `bit_en` strobe.
- Sits directly upstream of the serial even-parity detector and drives its serial input.

## Interface
- `DATA_W`, 8 — data bits per frame; must be ≥ 1.
- `STOP_BITS`, 1 — stop bits per frame; only 1 or 2 are legal, any other value is an elaboration error.

- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `bit_en`  in  1  — bit-period strobe; the line advances one bit on each rising edge where it is high.
- `dado_in`  in  DATA_W  — word to transmit; sampled only at acceptance.
- `valid_in`  in  1  — `dado_in` is valid.
- `ready_out`  out  1  — block can accept a word (high only in IDLE).
- `saida_serial`  out  1  — serial line, registered; idle level is 1.
- `ocupado`  out  1  — a frame is in progress (any state other than IDLE).
- `quadro_fim`  out  1  — one-cycle pulse at the end of a frame.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - `saida_serial` = 1, `ready_out` = 1.
  - Acceptance happens on a rising edge with `valid_in` & `ready_out` high.
  - At acceptance: latch `dado_in` into a shift register, compute parity as XOR-reduce of the word, go to START.
- START
  - Line = 0.
  - On `bit_en`: go to DATA, bit counter = 0.
- DATA
  - Line = shift register bit 0.
  - On `bit_en`: shift right, increment the counter.
  - When `bit_en` arrives with counter = DATA_W−1: go to PARITY.
- PARITY
  - Line = parity bit, so the data bits plus the parity bit always contain an even number of ones.
  - On `bit_en`: go to STOP, stop counter = 0.
- STOP
  - Line = 1.
  - On `bit_en` with stop counter = STOP_BITS−1: go to IDLE and assert `quadro_fim` for that one cycle.
  - Otherwise on `bit_en`: increment the stop counter.
- Frame length is 2 + DATA_W + STOP_BITS bit periods.
- Boundary rules:
  - `valid_in` while not IDLE is ignored; no back-pressure state is stored.
  - Changes on `dado_in` during a frame have no effect.
  - `bit_en` in IDLE is ignored.
  - If acceptance and `bit_en` coincide on the same edge, `bit_en` is ignored. START therefore lasts until the next `bit_en`, i.e. at least one cycle.
  - Reset mid-frame: the frame is aborted immediately, the FSM goes to IDLE, the line returns to 1, and no `quadro_fim` is issued.

## Timing
- Reset values:
  - state IDLE
  - `saida_serial` 1, `ready_out` 1, `ocupado` 0, `quadro_fim` 0
  - shift register, parity, counters 0
- `ready_out` and `ocupado` are decoded from the registered state.
- `saida_serial` and `quadro_fim` are registered.
- Latency:
  - Acceptance at edge k gives `saida_serial` = 0 from edge k onward.
  - Each later bit changes at the edge where `bit_en` is sampled high.
- `quadro_fim` is high in the same cycle the line finishes the last stop bit, i.e. the first IDLE cycle.
- `ready_out` = 1 in that same cycle, so back-to-back frames are possible with a minimum of one IDLE cycle between frames.

## Configuration
- Macro: `PARITY_FAULT_EN`.
- Defined:
  - Adds input `falha_paridade` (1 bit), sampled at acceptance.
  - If it was 1, the PARITY bit for that frame is inverted, for exercising the downstream detector.
- Undefined:
  - The port does not exist.
  - Parity is always correct.

## Structure
- Shared package holds:
  - the state enum typedef (2^n-encoded logic),
  - constants `LINHA_OCIOSA` = 1 and `BIT_START` = 0,
  - an even-parity function (XOR-reduce) reusable by the detector bench.
- No sub-module inside the block; the strobe generator `divisor_bit_en` lives outside and feeds `bit_en`.

## Test plan
Unless stated otherwise: DATA_W=8, STOP_BITS=1.
- `bit_en` held 1, send 0xA5 → line after acceptance: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, then `quadro_fim` pulse; 11 bit periods.
- Send 0x07 → data 1,1,1,0,0,0,0,0, parity 1.
- `bit_en` every 4th cycle, send 0xFF → each bit holds 4 cycles, parity 0; `valid_in` pulses with 0x00 mid-frame are ignored and the next frame is unaffected.
- Reset asserted during DATA bit 3 → line = 1 and `ready_out` = 1 immediately, no `quadro_fim`; the next word, 0x01, transmits correctly.
- STOP_BITS=2 → two 1-bits before IDLE, `quadro_fim` only after the second; back-to-back word accepted the cycle `quadro_fim` is high.
- `PARITY_FAULT_EN`, send 0xA5 with `falha_paridade`=1 → parity bit 1; the downstream detector flags an error.
